alu_wide: RTL and testbench



---
 rtl/alu_wide.sv | 219 +++++++++++++++++++++
 tb/tb_alu_wide.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wide.sv
// Slice-serial ALU: processes one SLICE-wide chunk per cycle.
// Valid/ready request and result handshakes around an IDLE/RUN/DONE FSM.
module alu_wide #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] data0_in,
  input  logic [WIDTH-1:0] data1_in,
  input  logic [3:0]       flags_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [3:0]       flags_out,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_ADC = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_SBC = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4;
  localparam logic [4:0] OP_OR  = 5'd5;
  localparam logic [4:0] OP_XOR = 5'd6;
  localparam logic [4:0] OP_CP  = 5'd7;
  localparam logic [4:0] OP_INC = 5'd8;
  localparam logic [4:0] OP_DEC = 5'd9;
  localparam logic [4:0] OP_RL  = 5'd10;
  localparam logic [4:0] OP_RR  = 5'd11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [NSLICE-1:0][SLICE-1:0] a_q;
  logic [NSLICE-1:0][SLICE-1:0] b_q;
  logic [NSLICE-1:0][SLICE-1:0] res_q;
  logic [4:0]    op_q;
  logic [3:0]    fl_q;
  logic [3:0]    flags_q;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          z_q;
  logic          h_q;

  logic k_add, k_sub, k_and, k_or, k_xor;
  logic k_rl, k_rr, k_pass, k_inc, k_dec, k_cp;
  logic accept, last;
  logic cin0;

  always_comb begin
    k_inc  = (op_q == OP_INC);
    k_dec  = (op_q == OP_DEC);
    k_cp   = (op_q == OP_CP);
    k_add  = op_q inside {OP_ADD, OP_ADC, OP_INC};
    k_sub  = op_q inside {OP_SUB, OP_SBC, OP_CP, OP_DEC};
    k_and  = (op_q == OP_AND);
    k_or   = (op_q == OP_OR);
    k_xor  = (op_q == OP_XOR);
    k_rl   = (op_q == OP_RL);
    k_rr   = (op_q == OP_RR);
    k_pass = ~(k_add | k_sub | k_and | k_or
               | k_xor | k_rl | k_rr);
  end

  // Initial carry/borrow seeded from the incoming opcode
  always_comb begin
    cin0 = 1'b0;
    case (op)
      OP_ADC, OP_SBC,
      OP_RL, OP_RR:   cin0 = flags_in[0];
      OP_INC, OP_DEC: cin0 = 1'b1;
      default:        cin0 = 1'b0;
    endcase
  end

  logic [CW-1:0]    idx;
  logic [SLICE-1:0] a_s, b_s, res_s;
  logic [SLICE:0]   sum, dif;
  logic [4:0]       hs, hd;
  logic             cout, h_s, h_now, z_now;
  logic [3:0]       flags_nxt;

  always_comb begin
    idx = k_rr ? (LAST - cnt) : cnt;
    a_s = a_q[idx];
    b_s = (k_inc | k_dec) ? '0 : b_q[idx];
    sum = {1'b0, a_s} + {1'b0, b_s}
          + {{SLICE{1'b0}}, carry};
    dif = {1'b0, a_s} - {1'b0, b_s}
          - {{SLICE{1'b0}}, carry};
    hs  = {1'b0, a_s[3:0]} + {1'b0, b_s[3:0]}
          + {4'b0, carry};
    hd  = {1'b0, a_s[3:0]} - {1'b0, b_s[3:0]}
          - {4'b0, carry};
    res_s = '0;
    cout  = 1'b0;
    h_s   = 1'b0;
    unique case (1'b1)
      k_add: begin
        res_s = sum[SLICE-1:0];
        cout  = sum[SLICE];
        h_s   = (hs > 5'd15);
      end
      k_sub: begin
        res_s = dif[SLICE-1:0];
        cout  = dif[SLICE];
        h_s   = (hd > 5'd15);
      end
      k_and:  res_s = a_s & b_s;
      k_or:   res_s = a_s | b_s;
      k_xor:  res_s = a_s ^ b_s;
      k_rl: begin
        res_s = {a_s[SLICE-2:0], carry};
        cout  = a_s[SLICE-1];
      end
      k_rr: begin
        res_s = {carry, a_s[SLICE-1:1]};
        cout  = a_s[0];
      end
      k_pass: res_s = b_s;
      default: ;
    endcase
  end

  // H only exists in the slice holding bits 3..0
  always_comb begin
    h_now = (cnt == '0) ? h_s : h_q;
    z_now = z_q & (res_s == '0);
    flags_nxt = fl_q;
    unique case (1'b1)
      k_add:  flags_nxt = {z_now, 1'b0, h_now,
                           k_inc ? fl_q[0] : cout};
      k_sub:  flags_nxt = {z_now, 1'b1, h_now,
                           k_dec ? fl_q[0] : cout};
      k_and:  flags_nxt = {z_now, 3'b010};
      k_or:   flags_nxt = {z_now, 3'b000};
      k_xor:  flags_nxt = {z_now, 3'b000};
      k_rl:   flags_nxt = {z_now, 2'b00, cout};
      k_rr:   flags_nxt = {z_now, 2'b00, cout};
      k_pass: flags_nxt = fl_q;
      default: ;
    endcase
  end

  assign accept = (state == IDLE) & in_valid & ~flush;
  assign last   = (cnt == LAST);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      fl_q    <= '0;
      flags_q <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      z_q     <= 1'b0;
      h_q     <= 1'b0;
    end else if (flush) begin
      cnt   <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      a_q   <= data1_in;
      b_q   <= data0_in;
      op_q  <= op;
      fl_q  <= flags_in;
      cnt   <= '0;
      carry <= cin0;
      z_q   <= 1'b1;
      h_q   <= 1'b0;
    end else if (state == RUN) begin
      res_q[idx] <= res_s;
      carry      <= cout;
      z_q        <= z_now;
      h_q        <= h_now;
      cnt        <= last ? '0 : cnt + CW'(1);
      if (last) flags_q <= flags_nxt;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign data_out  = !out_valid ? '0
                   : k_cp ? a_q : res_q;
  assign flags_out = out_valid ? flags_q : 4'b0;

endmodule

// File: tb/tb_alu_wide.sv
// Scoreboard bench for alu_wide: directed vectors, backpressure,
// flush/reset aborts; monitor pops expectations on each handshake.
module tb_alu_wide;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset, flush, in_valid, in_ready;
  logic         out_valid, out_ready, busy;
  logic [4:0]   op;
  logic [W-1:0] data0_in, data1_in, data_out;
  logic [3:0]   flags_in, flags_out;

  alu_wide #(.WIDTH(16), .SLICE(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .data0_in  (data0_in),
    .data1_in  (data1_in),
    .flags_in  (flags_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .flags_out (flags_out),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clock) cyc++;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [3:0]  fi;
    logic [15:0] ed;
    logic [3:0]  ef;
    string       nm;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  f;
    int          acc;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[18];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, req);
    end
  endtask

  logic prev_v = 1'b0;
  int   rise = 0;

  always @(negedge clock) begin
    exp_t e;
    if (out_valid === 1'b1 && prev_v !== 1'b1)
      rise = cyc;
    prev_v = out_valid;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: data=%h flags=%b",
                 data_out, flags_out);
      end else begin
        e = sbq.pop_front();
        chk({e.nm, "_data"}, 32'(data_out), 32'(e.d));
        chk({e.nm, "_flags"}, 32'(flags_out), 32'(e.f));
        chk({e.nm, "_latency"}, 32'(rise),
            32'(e.acc + 4));
      end
    end
  end

  task automatic issue(input vec_t v, input bit push);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk({v.nm, "_in_ready_wait"}, 32'(in_ready), 32'd1);
    op       = v.op;
    data0_in = v.d0;
    data1_in = v.d1;
    flags_in = v.fi;
    in_valid = 1'b1;
    if (push) sbq.push_back('{v.ed, v.ef, cyc + 1, v.nm});
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d results pending, 0 required",
               nm, sbq.size());
      sbq.delete();
    end
    @(posedge clock); #1;
  endtask

  initial begin
    logic [15:0] hold_d;
    logic [3:0]  hold_f;
    int n;

    vt[0]  = '{5'd0,  16'h0001, 16'h0FFF, 4'h0, 16'h1000, 4'b0010, "add"};
    vt[1]  = '{5'd2,  16'h0001, 16'h0000, 4'h0, 16'hFFFF, 4'b0111, "sub"};
    vt[2]  = '{5'd7,  16'h0001, 16'h0000, 4'h0, 16'h0000, 4'b0111, "cp"};
    vt[3]  = '{5'd1,  16'h0000, 16'hFFFF, 4'h1, 16'h0000, 4'b1011, "adc"};
    vt[4]  = '{5'd11, 16'h0000, 16'h0001, 4'h1, 16'h8000, 4'b0001, "rr"};
    vt[5]  = '{5'd8,  16'h0000, 16'hFFFF, 4'h1, 16'h0000, 4'b1011, "inc"};
    vt[6]  = '{5'd4,  16'hFF00, 16'hF0F0, 4'h0, 16'hF000, 4'b0010, "and"};
    vt[7]  = '{5'd5,  16'h0F00, 16'h00F0, 4'h0, 16'h0FF0, 4'b0000, "or"};
    vt[8]  = '{5'd6,  16'h1234, 16'h1234, 4'h0, 16'h0000, 4'b1000, "xor"};
    vt[9]  = '{5'd10, 16'h0000, 16'h8001, 4'h0, 16'h0002, 4'b0001, "rl"};
    vt[10] = '{5'd9,  16'h0000, 16'h0000, 4'h0, 16'hFFFF, 4'b0110, "dec"};
    vt[11] = '{5'd3,  16'h0000, 16'h1000, 4'h1, 16'h0FFF, 4'b0110, "sbc"};
    vt[12] = '{5'd15, 16'hABCD, 16'h1111, 4'h5, 16'hABCD, 4'b0101, "pass"};
    vt[13] = '{5'd0,  16'h8000, 16'h8000, 4'h0, 16'h0000, 4'b1001, "add_ovf"};
    vt[14] = '{5'd9,  16'h0000, 16'h0010, 4'h1, 16'h000F, 4'b0111, "dec_c"};
    vt[15] = '{5'd0,  16'h0001, 16'h0001, 4'h1, 16'h0002, 4'b0000, "add_noc"};
    vt[16] = '{5'd11, 16'h0000, 16'h1235, 4'h0, 16'h091A, 4'b0001, "rr2"};
    vt[17] = '{5'd10, 16'h0000, 16'h1234, 4'h1, 16'h2469, 4'b0000, "rl2"};

    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = '0;
    data0_in  = '0;
    data1_in  = '0;
    flags_in  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_flags", 32'(flags_out), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    foreach (vt[i]) begin
      issue(vt[i], 1'b1);
      chk({vt[i].nm, "_busy"}, 32'(busy), 32'd1);
      drain(vt[i].nm);
    end

    // Backpressure: hold DONE for three cycles
    out_ready = 1'b0;
    issue(vt[0], 1'b1);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("bp_reach_done", 32'(out_valid), 32'd1);
    hold_d   = data_out;
    hold_f   = flags_out;
    chk("bp_data_first", 32'(hold_d), 32'h1000);
    op       = 5'd6;
    data0_in = 16'h5555;
    data1_in = 16'hAAAA;
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_data_stable", 32'(data_out), 32'(hold_d));
      chk("bp_flags_stable", 32'(flags_out), 32'(hold_f));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp_in_ready_after", 32'(in_ready), 32'd1);
    chk("bp_data_idle", 32'(data_out), 32'd0);
    drain("bp");

    // flush in IDLE must block acceptance
    op       = 5'd0;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clock); #1;
    chk("flush_idle_busy", 32'(busy), 32'd0);
    chk("flush_idle_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (6) @(posedge clock);
    #1;

    // flush on the 2nd RUN cycle
    issue(vt[1], 1'b0);
    chk("abf_busy", 32'(busy), 32'd1);
    @(posedge clock); #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    chk("abf_in_ready", 32'(in_ready), 32'd1);
    chk("abf_busy_after", 32'(busy), 32'd0);
    chk("abf_out_valid", 32'(out_valid), 32'd0);
    repeat (6) @(posedge clock);
    #1;
    issue(vt[0], 1'b1);
    drain("abf_next");

    // reset on the 2nd RUN cycle
    issue(vt[2], 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abr_in_ready", 32'(in_ready), 32'd1);
    chk("abr_busy", 32'(busy), 32'd0);
    chk("abr_out_valid", 32'(out_valid), 32'd0);
    repeat (6) @(posedge clock);
    #1;
    issue(vt[3], 1'b1);
    drain("abr_next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
